// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite definitions (response codes, bridge FSM encodings) used by the
// master and slave bridges.
package axi4l_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    S_WIDLE = 2'd0,
    S_WADDR = 2'd1,
    S_WRESP = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    S_RIDLE = 2'd0,
    S_RADDR = 2'd1,
    S_RDATA = 2'd2
  } rd_state_e;

  // Byte-offset bits below the word address for a given AXI data width.
  function automatic int unsigned addr_ofs(input int unsigned data_width);
    return (data_width == 64) ? 32'd3 : 32'd2;
  endfunction

endpackage

// File: rtl/axi4l_timeout_cnt.sv
// Per-path response watchdog for axi4l_master_ipif; only compiled and instantiated
// when AXI4L_MASTER_TIMEOUT_EN is defined.
`ifdef AXI4L_MASTER_TIMEOUT_EN
module axi4l_timeout_cnt #(
  parameter int C_TIMEOUT = 1024
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(C_TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Count busy cycles, saturating at the limit; a new request restarts the count.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = {CW{1'b0}};
    end else if (enable && (cnt_q != CW'(C_TIMEOUT))) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && (cnt_q == CW'(C_TIMEOUT - 1));

endmodule
`endif

// File: rtl/axi4l_master_ipif.sv
// req/ack register interface to AXI4-Lite master with independent write and read paths.
// Optional per-path response watchdog: define AXI4L_MASTER_TIMEOUT_EN.
module axi4l_master_ipif
  import axi4l_pkg::*;
#(
  parameter  int C_ADDR_WIDTH = 12,
  parameter  int C_DATA_WIDTH = 32,
  parameter  int C_TIMEOUT    = 1024,
  localparam int OFS          = addr_ofs(C_DATA_WIDTH)
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      wr_req,
  input  logic [C_ADDR_WIDTH-OFS-1:0] wr_addr,
  input  logic [C_DATA_WIDTH-1:0]   wr_data,
  input  logic [C_DATA_WIDTH/8-1:0] wr_be,
  output logic                      wr_ack,
  output logic [1:0]                wr_resp,
  output logic                      wr_busy,
  input  logic                      rd_req,
  input  logic [C_ADDR_WIDTH-OFS-1:0] rd_addr,
  output logic                      rd_ack,
  output logic [C_DATA_WIDTH-1:0]   rd_data,
  output logic [1:0]                rd_resp,
  output logic                      rd_busy,
  output logic [31:0]               m_axi_awaddr,
  output logic [2:0]                m_axi_awprot,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [C_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  output logic [31:0]               m_axi_araddr,
  output logic [2:0]                m_axi_arprot,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [C_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready
);

  if ((C_DATA_WIDTH != 32) && (C_DATA_WIDTH != 64)) begin : g_bad_dw
    $error("axi4l_master_ipif: C_DATA_WIDTH must be 32 or 64");
  end
  if (C_TIMEOUT < 1) begin : g_bad_tmo
    $error("axi4l_master_ipif: C_TIMEOUT must be at least 1");
  end

  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic arvalid_q, arvalid_d, rready_q, rready_d;
  logic [31:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [C_DATA_WIDTH-1:0] wdata_q, wdata_d, rd_data_q, rd_data_d;
  logic [C_DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic wr_ack_q, wr_ack_d, rd_ack_q, rd_ack_d;
  logic wr_busy_q, wr_busy_d, rd_busy_q, rd_busy_d;
  logic [1:0] wr_resp_q, wr_resp_d, rd_resp_q, rd_resp_d;
  logic [31:0] wr_byte_addr_s, rd_byte_addr_s;
  logic wr_tmo_s, rd_tmo_s;

  assign wr_byte_addr_s = 32'(wr_addr) << OFS;
  assign rd_byte_addr_s = 32'(rd_addr) << OFS;

`ifdef AXI4L_MASTER_TIMEOUT_EN
  axi4l_timeout_cnt #(.C_TIMEOUT(C_TIMEOUT)) u_wr_tmo (
    .aclk(aclk), .aresetn(aresetn), .clear(wr_req && (wr_state_q == S_WIDLE)),
    .enable(wr_busy_q), .expired(wr_tmo_s));
  axi4l_timeout_cnt #(.C_TIMEOUT(C_TIMEOUT)) u_rd_tmo (
    .aclk(aclk), .aresetn(aresetn), .clear(rd_req && (rd_state_q == S_RIDLE)),
    .enable(rd_busy_q), .expired(rd_tmo_s));
`else
  assign wr_tmo_s = 1'b0;
  assign rd_tmo_s = 1'b0;
`endif

  // Write path: AW and W retire independently, then wait for B.
  always_comb begin
    wr_state_d = wr_state_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    bready_d   = bready_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    wr_ack_d   = 1'b0;
    wr_resp_d  = wr_resp_q;
    case (wr_state_q)
      S_WIDLE: begin
        if (wr_req) begin
          wr_state_d = S_WADDR;
          awvalid_d  = 1'b1;
          wvalid_d   = 1'b1;
          awaddr_d   = wr_byte_addr_s;
          wdata_d    = wr_data;
          wstrb_d    = wr_be;
        end else begin
          wr_state_d = S_WIDLE;
        end
      end
      S_WADDR: begin
        awvalid_d = awvalid_q && !m_axi_awready;
        wvalid_d  = wvalid_q && !m_axi_wready;
        if (!awvalid_d && !wvalid_d) begin
          wr_state_d = S_WRESP;
          bready_d   = 1'b1;
        end else begin
          wr_state_d = S_WADDR;
        end
      end
      S_WRESP: begin
        if (m_axi_bvalid && bready_q) begin
          wr_state_d = S_WIDLE;
          bready_d   = 1'b0;
          wr_ack_d   = 1'b1;
          wr_resp_d  = m_axi_bresp;
        end else begin
          wr_state_d = S_WRESP;
        end
      end
      default: begin
        wr_state_d = S_WIDLE;
        awvalid_d  = 1'b0;
        wvalid_d   = 1'b0;
        bready_d   = 1'b0;
      end
    endcase
    // Watchdog recovery abandons the handshake; a real response in the same cycle wins.
    if (wr_tmo_s && !wr_ack_d) begin
      wr_state_d = S_WIDLE;
      awvalid_d  = 1'b0;
      wvalid_d   = 1'b0;
      bready_d   = 1'b0;
      wr_ack_d   = 1'b1;
      wr_resp_d  = RESP_DECERR;
    end else begin
      wr_resp_d  = wr_resp_d;
    end
    wr_busy_d = (wr_state_d != S_WIDLE);
  end

  // Read path: AR handshake, then wait for R.
  always_comb begin
    rd_state_d = rd_state_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    araddr_d   = araddr_q;
    rd_ack_d   = 1'b0;
    rd_data_d  = rd_data_q;
    rd_resp_d  = rd_resp_q;
    case (rd_state_q)
      S_RIDLE: begin
        if (rd_req) begin
          rd_state_d = S_RADDR;
          arvalid_d  = 1'b1;
          araddr_d   = rd_byte_addr_s;
        end else begin
          rd_state_d = S_RIDLE;
        end
      end
      S_RADDR: begin
        if (m_axi_arready) begin
          rd_state_d = S_RDATA;
          arvalid_d  = 1'b0;
          rready_d   = 1'b1;
        end else begin
          rd_state_d = S_RADDR;
        end
      end
      S_RDATA: begin
        if (m_axi_rvalid && rready_q) begin
          rd_state_d = S_RIDLE;
          rready_d   = 1'b0;
          rd_ack_d   = 1'b1;
          rd_data_d  = m_axi_rdata;
          rd_resp_d  = m_axi_rresp;
        end else begin
          rd_state_d = S_RDATA;
        end
      end
      default: begin
        rd_state_d = S_RIDLE;
        arvalid_d  = 1'b0;
        rready_d   = 1'b0;
      end
    endcase
    if (rd_tmo_s && !rd_ack_d) begin
      rd_state_d = S_RIDLE;
      arvalid_d  = 1'b0;
      rready_d   = 1'b0;
      rd_ack_d   = 1'b1;
      rd_data_d  = {C_DATA_WIDTH{1'b0}};
      rd_resp_d  = RESP_DECERR;
    end else begin
      rd_resp_d  = rd_resp_d;
    end
    rd_busy_d = (rd_state_d != S_RIDLE);
  end

  // State and output registers for both paths.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_state_q <= S_WIDLE;
      rd_state_q <= S_RIDLE;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      awaddr_q   <= 32'd0;
      araddr_q   <= 32'd0;
      wdata_q    <= {C_DATA_WIDTH{1'b0}};
      wstrb_q    <= {(C_DATA_WIDTH/8){1'b0}};
      rd_data_q  <= {C_DATA_WIDTH{1'b0}};
      wr_ack_q   <= 1'b0;
      rd_ack_q   <= 1'b0;
      wr_busy_q  <= 1'b0;
      rd_busy_q  <= 1'b0;
      wr_resp_q  <= RESP_OKAY;
      rd_resp_q  <= RESP_OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      bready_q   <= bready_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      awaddr_q   <= awaddr_d;
      araddr_q   <= araddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      rd_data_q  <= rd_data_d;
      wr_ack_q   <= wr_ack_d;
      rd_ack_q   <= rd_ack_d;
      wr_busy_q  <= wr_busy_d;
      rd_busy_q  <= rd_busy_d;
      wr_resp_q  <= wr_resp_d;
      rd_resp_q  <= rd_resp_d;
    end
  end

  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;
  assign wr_ack        = wr_ack_q;
  assign wr_resp       = wr_resp_q;
  assign wr_busy       = wr_busy_q;
  assign rd_ack        = rd_ack_q;
  assign rd_data       = rd_data_q;
  assign rd_resp       = rd_resp_q;
  assign rd_busy       = rd_busy_q;

endmodule
